// File: rtl/ibus_dbus_arbiter.sv
// ibus_dbus_arbiter: shares one SRAM-like bus between the instruction-fetch
// port and the MEM-stage data port. The data side wins ties because it
// belongs to the older instruction. Each side raises a stall request until its
// access has completed. A flush lets any in-flight access finish on the bus
// but throws away its result.
//
// Handshake: bus_req_o and the other bus_* outputs stay constant from issue
// until the cycle in which bus_ack_i is sampled high. bus_ack_i is a
// single-cycle pulse, and bus_rdata_i is valid only in that cycle. An ack
// that arrives while no request is outstanding is ignored.
module ibus_dbus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_ce_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_inst_o,
  output logic                stallreq_if_o,
  input  logic                mem_ce_i,
  input  logic                mem_we_i,
  input  logic [DATA_W/8-1:0] mem_sel_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_data_i,
  output logic [DATA_W-1:0]   mem_data_o,
  output logic                stallreq_mem_o,
  input  logic                stall_i,
  input  logic                flush_i,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [DATA_W/8-1:0] bus_sel_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  input  logic                bus_ack_i,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  output logic [1:0]          dbg_state
);

  localparam int SEL_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_BUSY  = 2'd1,
    MEM_BUSY = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic                if_hold, mem_hold;
  logic                if_hold_nxt, mem_hold_nxt;
  logic                set_if, set_mem;
  logic                req_nxt, we_nxt;
  logic [SEL_W-1:0]    sel_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   wdata_nxt, inst_nxt, mdata_nxt;
  logic                hold_clear;

  // A hold marks data that the stalled pipeline has not consumed yet, so it
  // masks that side's stall request.
  assign stallreq_if_o  = if_ce_i & ~if_hold & ~rst;
  assign stallreq_mem_o = mem_ce_i & ~mem_hold & ~rst;
  assign dbg_state      = state;

  // The pipeline consumes the held data on any cycle in which it advances or
  // flushes.
  assign hold_clear = ~stall_i | flush_i;

  // Next-state logic, bus command, result capture and hold update.
  always_comb begin
    state_nxt = state;
    req_nxt   = bus_req_o;
    we_nxt    = bus_we_o;
    sel_nxt   = bus_sel_o;
    addr_nxt  = bus_addr_o;
    wdata_nxt = bus_wdata_o;
    inst_nxt  = if_inst_o;
    mdata_nxt = mem_data_o;
    set_if    = 1'b0;
    set_mem   = 1'b0;

    case (state)
      IDLE: begin
        if (mem_ce_i && !mem_hold && !flush_i) begin
          req_nxt   = 1'b1;
          we_nxt    = mem_we_i;
          sel_nxt   = mem_sel_i;
          addr_nxt  = mem_addr_i;
          wdata_nxt = mem_data_i;
          state_nxt = MEM_BUSY;
        end else if (if_ce_i && !if_hold && !flush_i) begin
          req_nxt   = 1'b1;
          we_nxt    = 1'b0;
          sel_nxt   = '1;
          addr_nxt  = if_addr_i;
          state_nxt = IF_BUSY;
        end
      end
      IF_BUSY: begin
        if (bus_ack_i) begin
          req_nxt   = 1'b0;
          we_nxt    = 1'b0;
          state_nxt = IDLE;
          if (!flush_i) begin
            inst_nxt = bus_rdata_i;
            set_if   = 1'b1;
          end
        end else if (flush_i) begin
          state_nxt = DRAIN;
        end
      end
      MEM_BUSY: begin
        if (bus_ack_i) begin
          req_nxt   = 1'b0;
          we_nxt    = 1'b0;
          state_nxt = IDLE;
          if (!flush_i) begin
            if (!bus_we_o) mdata_nxt = bus_rdata_i;
            set_mem = 1'b1;
          end
        end else if (flush_i) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // The transaction runs to completion on the bus. Its data is discarded.
        if (bus_ack_i) begin
          req_nxt   = 1'b0;
          we_nxt    = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Setting a hold outranks clearing it only while the pipeline is held.
    // set_* already implies that flush_i is low.
    if (set_if && stall_i) if_hold_nxt = 1'b1;
    else if (hold_clear)   if_hold_nxt = 1'b0;
    else                   if_hold_nxt = if_hold;

    if (set_mem && stall_i) mem_hold_nxt = 1'b1;
    else if (hold_clear)    mem_hold_nxt = 1'b0;
    else                    mem_hold_nxt = mem_hold;
  end

  // State register and registered outputs. Reset abandons any access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      if_inst_o   <= '0;
      mem_data_o  <= '0;
      if_hold     <= 1'b0;
      mem_hold    <= 1'b0;
    end else begin
      state       <= state_nxt;
      bus_req_o   <= req_nxt;
      bus_we_o    <= we_nxt;
      bus_sel_o   <= sel_nxt;
      bus_addr_o  <= addr_nxt;
      bus_wdata_o <= wdata_nxt;
      if_inst_o   <= inst_nxt;
      mem_data_o  <= mdata_nxt;
      if_hold     <= if_hold_nxt;
      mem_hold    <= mem_hold_nxt;
    end
  end

endmodule

// File: tb/tb_ibus_dbus_arbiter.sv
// tb_ibus_dbus_arbiter: directed scenarios followed by randomized traffic.
// Every cycle is compared against a transaction-level reference model.
module tb_ibus_dbus_arbiter;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce, mem_ce, mem_we, stall, flush, ack;
  logic [31:0] if_addr, mem_addr, mem_data, rdata;
  logic [3:0]  mem_sel;
  logic [31:0] if_inst_o, mem_data_o, bus_addr_o, bus_wdata_o;
  logic        stallreq_if_o, stallreq_mem_o, bus_req_o, bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  ibus_dbus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce), .if_addr_i(if_addr), .if_inst_o(if_inst_o),
    .stallreq_if_o(stallreq_if_o),
    .mem_ce_i(mem_ce), .mem_we_i(mem_we), .mem_sel_i(mem_sel),
    .mem_addr_i(mem_addr), .mem_data_i(mem_data), .mem_data_o(mem_data_o),
    .stallreq_mem_o(stallreq_mem_o),
    .stall_i(stall), .flush_i(flush),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(ack), .bus_rdata_i(rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_bad    = 0;
  // Delivered results in order: bit 32 is the side (1 = data, 0 = fetch).
  logic [32:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract view: at most one outstanding transaction (m_busy). A flushed
  // transaction is marked as discarded and completes without any effect.
  logic        m_busy, m_side, m_we, m_discard, m_if_hold, m_mem_hold;
  logic [3:0]  m_sel;
  logic [31:0] m_addr, m_wdata, m_inst, m_mdata;

  task automatic model_step();
    logic set_i, set_m;
    if (rst) begin
      m_busy = 0; m_side = 0; m_we = 0; m_discard = 0; m_if_hold = 0; m_mem_hold = 0;
      m_sel = 0; m_addr = 0; m_wdata = 0; m_inst = 0; m_mdata = 0;
      exp_q.delete();
      return;
    end
    set_i = 0; set_m = 0;
    if (!m_busy) begin
      if (mem_ce && !m_mem_hold && !flush) begin
        m_busy = 1; m_side = 1; m_discard = 0;
        m_we = mem_we; m_sel = mem_sel; m_addr = mem_addr; m_wdata = mem_data;
      end else if (if_ce && !m_if_hold && !flush) begin
        m_busy = 1; m_side = 0; m_discard = 0;
        m_we = 0; m_sel = 4'hf; m_addr = if_addr;
      end
    end else if (ack) begin
      if (!m_discard && !flush) begin
        if (!m_side) begin
          exp_q.push_back({1'b0, rdata});
          set_i = stall;
        end else begin
          if (!m_we) exp_q.push_back({1'b1, rdata});
          set_m = stall;
        end
      end
      m_busy = 0; m_we = 0; m_discard = 0;
    end else if (flush) begin
      m_discard = 1;
    end
    m_if_hold  = set_i ? 1'b1 : ((!stall || flush) ? 1'b0 : m_if_hold);
    m_mem_hold = set_m ? 1'b1 : ((!stall || flush) ? 1'b0 : m_mem_hold);
  endtask

  function automatic logic exp_sr_if();
    return if_ce && !m_if_hold && !rst;
  endfunction
  function automatic logic exp_sr_mem();
    return mem_ce && !m_mem_hold && !rst;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  // Inputs are set before the call, at a negedge. The task checks the
  // combinational stall requests, advances the model, crosses the posedge and
  // checks the registered outputs at the following negedge.
  task automatic tick();
    logic [32:0] e;
    #1;
    check_eq("stallreq_if", {31'd0, stallreq_if_o}, {31'd0, exp_sr_if()});
    check_eq("stallreq_mem", {31'd0, stallreq_mem_o}, {31'd0, exp_sr_mem()});
    model_step();
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e[32]) m_mdata = e[31:0];
      else       m_inst  = e[31:0];
    end
    check_eq("bus_req", {31'd0, bus_req_o}, {31'd0, m_busy});
    check_eq("bus_we", {31'd0, bus_we_o}, {31'd0, m_we});
    check_eq("bus_sel", {28'd0, bus_sel_o}, {28'd0, m_sel});
    check_eq("bus_addr", bus_addr_o, m_addr);
    check_eq("bus_wdata", bus_wdata_o, m_wdata);
    check_eq("if_inst", if_inst_o, m_inst);
    check_eq("mem_data", mem_data_o, m_mdata);
  endtask

  task automatic quiet_inputs();
    rst = 0; if_ce = 0; mem_ce = 0; mem_we = 0; stall = 0; flush = 0; ack = 0;
    if_addr = 0; mem_addr = 0; mem_data = 0; rdata = 0; mem_sel = 0;
  endtask

  // ---------------- stimulus ----------------
  int wait_cnt;

  initial begin
    quiet_inputs();
    rst = 1;
    tick();
    check_eq("reset_state", {30'd0, dbg_state}, 32'd0);
    rst = 0;

    // Fetch with two wait cycles, then a four-cycle stall while data is held.
    if_ce = 1; if_addr = 32'hbfc00000; stall = 1;
    tick();
    check_eq("fetch_addr", bus_addr_o, 32'hbfc00000);
    tick(); tick();
    ack = 1; rdata = 32'h3c010001;
    tick();
    check_eq("fetch_inst", if_inst_o, 32'h3c010001);
    ack = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("held_inst", if_inst_o, 32'h3c010001);
    end
    stall = 0; if_addr = 32'hbfc00004;
    tick();
    stall = 1;
    tick();
    check_eq("next_fetch_addr", bus_addr_o, 32'hbfc00004);
    ack = 1; rdata = 32'h24210002;
    tick();
    ack = 0; stall = 0; if_ce = 0;
    tick();

    // Data read and fetch requested together: data goes first.
    mem_ce = 1; mem_we = 0; mem_sel = 4'hf; mem_addr = 32'h80000010;
    if_ce = 1; if_addr = 32'hbfc00008; stall = 1;
    tick();
    check_eq("conflict_first", bus_addr_o, 32'h80000010);
    ack = 1; rdata = 32'h11112222;
    tick();
    ack = 0;
    tick();
    check_eq("conflict_second", bus_addr_o, 32'hbfc00008);
    ack = 1; rdata = 32'h33334444;
    tick();
    check_eq("conflict_mdata", mem_data_o, 32'h11112222);
    ack = 0;
    tick();
    stall = 0; mem_ce = 0; if_ce = 0;
    tick();

    // Partial write: read data is left untouched.
    mem_ce = 1; mem_we = 1; mem_sel = 4'b0011; mem_addr = 32'h80000020;
    mem_data = 32'hdeadbeef; stall = 1;
    tick();
    check_eq("wr_we", {31'd0, bus_we_o}, 32'd1);
    check_eq("wr_sel", {28'd0, bus_sel_o}, 32'h3);
    check_eq("wr_data", bus_wdata_o, 32'hdeadbeef);
    ack = 1; rdata = 32'h55555555;
    tick();
    check_eq("wr_mdata", mem_data_o, 32'h11112222);
    ack = 0; stall = 0; mem_ce = 0; mem_we = 0;
    tick();

    // Flush during a fetch: the access drains and its result is dropped.
    if_ce = 1; if_addr = 32'hbfc00010; stall = 1;
    tick();
    flush = 1;
    tick();
    check_eq("drain_state", {30'd0, dbg_state}, 32'd3);
    flush = 0; if_addr = 32'hbfc00380;
    tick(); tick();
    ack = 1; rdata = 32'h12345678;
    tick();
    check_eq("drain_inst", if_inst_o, 32'h33334444);
    ack = 0;
    tick();
    check_eq("new_pc_addr", bus_addr_o, 32'hbfc00380);
    ack = 1; rdata = 32'h00000000;
    tick();
    ack = 0; stall = 0; if_ce = 0;
    tick();

    // Reset in the middle of a data access, then a stray ack.
    mem_ce = 1; mem_we = 0; mem_addr = 32'h80000030; stall = 1;
    tick(); tick();
    rst = 1;
    tick();
    check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
    quiet_inputs();
    ack = 1; rdata = 32'hffffffff;
    tick();
    check_eq("stray_ack_state", {30'd0, dbg_state}, 32'd0);
    ack = 0;
    tick();

    // Randomized traffic with a responsive bus slave.
    wait_cnt = $urandom_range(0, 3);
    for (int c = 0; c < 2000; c++) begin
      rst      = ($urandom_range(0, 199) == 0);
      if_ce    = ($urandom_range(0, 3) != 0);
      if_addr  = $urandom;
      mem_ce   = ($urandom_range(0, 2) == 0);
      mem_we   = $urandom_range(0, 1);
      mem_sel  = 4'($urandom_range(0, 15));
      mem_addr = $urandom;
      mem_data = $urandom;
      flush    = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) stall = $urandom_range(0, 1);
      else                           stall = exp_sr_if() || exp_sr_mem();
      rdata = $urandom;
      ack   = 0;
      if (bus_req_o) begin
        if (wait_cnt == 0) begin
          ack = 1;
          wait_cnt = $urandom_range(0, 3);
        end else begin
          wait_cnt--;
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
